// File: rtl/clock_ctrl_pkg.sv
// Shared types, digit indices, digit limits and BCD helpers for the clock-set controller.
// Digit limits keep the shadow value a legal 24-hour time at all times.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Digit order matches cur_bcd packing {h_hi, h_lo, m_hi, m_lo}
   typedef logic [3:0][3:0] shadow_t;

   localparam logic [1:0] M_LO = 2'd0;
   localparam logic [1:0] M_HI = 2'd1;
   localparam logic [1:0] H_LO = 2'd2;
   localparam logic [1:0] H_HI = 2'd3;

   localparam logic [3:0] M_LO_MAX       = 4'd9;
   localparam logic [3:0] M_HI_MAX       = 4'd5;
   localparam logic [3:0] H_LO_MAX       = 4'd9;
   localparam logic [3:0] H_HI_MAX       = 4'd2;
   localparam logic [3:0] H_LO_MAX_AT_20 = 4'd3;

   function automatic logic [3:0] digit_max(input shadow_t d, input logic [1:0] idx);
      logic [3:0] m;
      case (idx)
         M_LO:    m = M_LO_MAX;
         M_HI:    m = M_HI_MAX;
         H_LO:    m = (d[H_HI] == H_HI_MAX) ? H_LO_MAX_AT_20 : H_LO_MAX;
         default: m = H_HI_MAX;
      endcase
      return m;
   endfunction

   // h_hi is clamped first so the h_lo limit sees the final hour tens digit
   function automatic shadow_t clamp_bcd(input logic [15:0] bcd);
      shadow_t d;
      d = shadow_t'(bcd);
      if (d[H_HI] > H_HI_MAX) d[H_HI] = H_HI_MAX;
      if (d[M_HI] > M_HI_MAX) d[M_HI] = M_HI_MAX;
      if (d[M_LO] > M_LO_MAX) d[M_LO] = M_LO_MAX;
      if (d[H_LO] > digit_max(d, H_LO)) d[H_LO] = digit_max(d, H_LO);
      return d;
   endfunction

   function automatic shadow_t inc_digit(input shadow_t d, input logic [1:0] idx);
      shadow_t r;
      r = d;
      if (d[idx] >= digit_max(d, idx)) r[idx] = '0;
      else                             r[idx] = d[idx] + 4'd1;
      if (r[H_HI] == H_HI_MAX && r[H_LO] > H_LO_MAX_AT_20) r[H_LO] = H_LO_MAX_AT_20;
      return r;
   endfunction

endpackage

// File: rtl/key_cond.sv
// Button conditioner: 2-flop synchronizer, optional stability filter, rising-edge pulse.
// Define CLOCK_SET_DEBOUNCE_EN to require DB_CYCLES of stable level before an edge is accepted.
module key_cond #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic rise
);

   logic [1:0] sync;

   if (DB_CYCLES < 1) begin : g_db_check
      $error("key_cond: DB_CYCLES must be at least 1");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[0], key};
   end

`ifdef CLOCK_SET_DEBOUNCE_EN
   localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [DB_W-1:0] db_cnt;
   logic            stable;
   logic            stable_d;

   // The counter only runs while the synchronized level disagrees with the accepted one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt   <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
      end else begin
         stable_d <= stable;
         if (sync[1] == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable <= sync[1];
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign rise = stable & ~stable_d;
`else
   logic sync_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_d <= 1'b0;
      else        sync_d <= sync[1];
   end

   assign rise = sync[1] & ~sync_d;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Three-button time-setting controller: snapshot, per-digit edit with blink, timed commit.
// Optional macro CLOCK_SET_DEBOUNCE_EN enables the key stability filter in key_cond.
module clock_set_ctrl #(
   parameter int unsigned HOLD_CYCLES  = 60_000_000,
   parameter int unsigned BLINK_CYCLES = 12_500_000,
   parameter int unsigned DB_CYCLES    = 1_000_000
) (
   input  logic        CLOCK_50,
   input  logic        clrn,
   input  logic        key_mode,
   input  logic        key_next,
   input  logic        key_inc,
   input  logic [15:0] cur_bcd,
   output logic        pause,
   output logic [1:0]  sel,
   output logic [3:0]  load,
   output logic [3:0]  blink_mask,
   output logic        commit_done
);
   import clock_ctrl_pkg::*;

   localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   logic mode_rise;
   logic next_rise;
   logic inc_rise;

   state_t             state, state_n;
   shadow_t            shadow, shadow_n;
   logic [1:0]         sel_n;
   logic [HOLD_W-1:0]  hold_cnt, hold_n;
   logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
   logic               phase, phase_n;

   key_cond #(.DB_CYCLES(DB_CYCLES)) u_key_mode (
      .clk(CLOCK_50), .rst_n(clrn), .key(key_mode), .rise(mode_rise)
   );
   key_cond #(.DB_CYCLES(DB_CYCLES)) u_key_next (
      .clk(CLOCK_50), .rst_n(clrn), .key(key_next), .rise(next_rise)
   );
   key_cond #(.DB_CYCLES(DB_CYCLES)) u_key_inc (
      .clk(CLOCK_50), .rst_n(clrn), .key(key_inc), .rise(inc_rise)
   );

   always_comb begin
      state_n     = state;
      shadow_n    = shadow;
      sel_n       = sel;
      hold_n      = hold_cnt;
      blink_cnt_n = blink_cnt;
      phase_n     = phase;

      case (state)
         RUN: begin
            if (mode_rise) begin
               state_n  = EDIT;
               shadow_n = clamp_bcd(cur_bcd);
               sel_n    = H_HI;
            end
         end
         EDIT: begin
            if (mode_rise) begin
               state_n = COMMIT;
               sel_n   = M_LO;
               hold_n  = '0;
            end else begin
               // inc acts on the current digit before next moves the selection
               if (inc_rise)  shadow_n = inc_digit(shadow, sel);
               if (next_rise) sel_n    = sel - 2'd1;
            end
         end
         COMMIT: begin
            if (hold_cnt == HOLD_LAST) begin
               hold_n = '0;
               if (sel == H_HI) begin
                  state_n = RUN;
                  sel_n   = M_LO;
               end else begin
                  sel_n = sel + 2'd1;
               end
            end else begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         default: state_n = RUN;
      endcase

      if (state != EDIT || sel_n != sel) begin
         blink_cnt_n = '0;
         phase_n     = 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt_n = '0;
         phase_n     = ~phase;
      end else begin
         blink_cnt_n = blink_cnt + 1'b1;
      end
   end

   // Outputs are built from next-state values so they line up with the registered state
   always_ff @(posedge CLOCK_50 or negedge clrn) begin
      if (!clrn) begin
         state       <= RUN;
         shadow      <= '0;
         sel         <= '0;
         hold_cnt    <= '0;
         blink_cnt   <= '0;
         phase       <= 1'b0;
         pause       <= 1'b0;
         load        <= '0;
         blink_mask  <= '0;
         commit_done <= 1'b0;
      end else begin
         state       <= state_n;
         shadow      <= shadow_n;
         sel         <= sel_n;
         hold_cnt    <= hold_n;
         blink_cnt   <= blink_cnt_n;
         phase       <= phase_n;
         pause       <= (state_n != RUN);
         load        <= (state_n == RUN) ? 4'd0 : shadow_n[sel_n];
         blink_mask  <= (state_n == EDIT && phase_n) ? (4'b0001 << sel_n) : 4'b0000;
         commit_done <= (state_n == COMMIT) && (sel_n == H_HI) && (hold_n == HOLD_LAST);
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (HOLD_CYCLES=4, BLINK_CYCLES=2, DB_CYCLES=3).
// Also covers the CLOCK_SET_DEBOUNCE_EN build when that macro is defined.
module tb_clock_set_ctrl;

   localparam int unsigned HOLD  = 4;
   localparam int unsigned BLINK = 2;
   localparam int unsigned DB    = 3;
`ifdef CLOCK_SET_DEBOUNCE_EN
   localparam int unsigned LAT = 8;
`else
   localparam int unsigned LAT = 4;
`endif

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        key_mode = 1'b0;
   logic        key_next = 1'b0;
   logic        key_inc = 1'b0;
   logic [15:0] cur_bcd = '0;
   logic        pause;
   logic [1:0]  sel;
   logic [3:0]  load;
   logic [3:0]  blink_mask;
   logic        commit_done;

   int n_checks = 0;
   int n_pass   = 0;

   always #10 clk = ~clk;

   clock_set_ctrl #(
      .HOLD_CYCLES(HOLD),
      .BLINK_CYCLES(BLINK),
      .DB_CYCLES(DB)
   ) dut (
      .CLOCK_50(clk),
      .clrn(clrn),
      .key_mode(key_mode),
      .key_next(key_next),
      .key_inc(key_inc),
      .cur_bcd(cur_bcd),
      .pause(pause),
      .sel(sel),
      .load(load),
      .blink_mask(blink_mask),
      .commit_done(commit_done)
   );

   task automatic do_reset();
      @(negedge clk);
      key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
   endtask

   task automatic press(input logic m, input logic n, input logic i);
      key_mode = m; key_next = n; key_inc = i;
      repeat (5) @(negedge clk);
      key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (pause !== 1'b0) $display("FAIL reset_pause: got %0b want 0", pause); else n_pass++;
      n_checks++; if (sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", sel); else n_pass++;
      n_checks++; if (load !== 4'd0) $display("FAIL reset_load: got %0d want 0", load); else n_pass++;
      n_checks++; if (blink_mask !== 4'b0000) $display("FAIL reset_blink: got %b want 0000", blink_mask); else n_pass++;
      n_checks++; if (commit_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", commit_done); else n_pass++;
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (pause !== 1'b0) $display("FAIL reset_stays_run: pause got %0b want 0", pause); else n_pass++;
   endtask

   task automatic test_entry();
      int lat;
      logic [3:0] exp_blink [4];
      exp_blink = '{4'b1000, 4'b0000, 4'b0000, 4'b1000};
      do_reset();
      cur_bcd = 16'h2359;
      key_mode = 1'b1;
      lat = 0;
      for (int c = 1; c <= int'(LAT) + 4 && lat == 0; c++) begin
         @(negedge clk);
         if (pause === 1'b1) lat = c;
      end
      key_mode = 1'b0;
      n_checks++; if (lat == 0 || lat > int'(LAT)) $display("FAIL entry_latency: got %0d cycles want 1..%0d", lat, LAT); else n_pass++;
      n_checks++; if (sel !== 2'd3) $display("FAIL entry_sel: got %0d want 3", sel); else n_pass++;
      n_checks++; if (load !== 4'd2) $display("FAIL entry_load: got %0d want 2", load); else n_pass++;
      n_checks++; if (blink_mask !== 4'b1000) $display("FAIL entry_blink: got %b want 1000", blink_mask); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (blink_mask !== exp_blink[k]) $display("FAIL blink_phase[%0d]: got %b want %b", k, blink_mask, exp_blink[k]);
         else n_pass++;
      end
      repeat (8) @(negedge clk);
      press(1'b0, 1'b0, 1'b1);
      n_checks++; if (load !== 4'd0) $display("FAIL h_hi_wrap: got %0d want 0", load); else n_pass++;
   endtask

   task automatic test_clamp();
      do_reset();
      cur_bcd = 16'h1959;
      press(1'b1, 1'b0, 1'b0);
      n_checks++; if (sel !== 2'd3 || load !== 4'd1) $display("FAIL clamp_enter: got sel=%0d load=%0d want 3/1", sel, load); else n_pass++;
      press(1'b0, 1'b0, 1'b1);
      n_checks++; if (load !== 4'd2) $display("FAIL clamp_inc: got %0d want 2", load); else n_pass++;
      press(1'b0, 1'b1, 1'b0);
      n_checks++; if (sel !== 2'd2 || load !== 4'd3) $display("FAIL clamp_h_lo: got sel=%0d load=%0d want 2/3", sel, load); else n_pass++;
   endtask

   task automatic test_snapshot_clamp();
      logic [3:0] exp_ld [4];
      exp_ld = '{4'd2, 4'd3, 4'd5, 4'd9};
      do_reset();
      cur_bcd = 16'h3F7A;
      press(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (sel !== 2'(3 - k) || load !== exp_ld[k])
            $display("FAIL snapshot_clamp[%0d]: got sel=%0d load=%0d want %0d/%0d", k, sel, load, 3 - k, exp_ld[k]);
         else n_pass++;
         press(1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      cur_bcd = 16'h1459;
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      n_checks++; if (sel !== 2'd1 || load !== 4'd5) $display("FAIL wrap_at_m_hi: got sel=%0d load=%0d want 1/5", sel, load); else n_pass++;
      press(1'b0, 1'b0, 1'b1);
      n_checks++; if (load !== 4'd0) $display("FAIL m_hi_wrap: got %0d want 0", load); else n_pass++;
      press(1'b0, 1'b1, 1'b0);
      n_checks++; if (sel !== 2'd0 || load !== 4'd9) $display("FAIL no_carry_m_lo: got sel=%0d load=%0d want 0/9", sel, load); else n_pass++;
      press(1'b0, 1'b0, 1'b1);
      n_checks++; if (load !== 4'd0) $display("FAIL m_lo_wrap: got %0d want 0", load); else n_pass++;
      press(1'b0, 1'b1, 1'b0);
      n_checks++; if (sel !== 2'd3 || load !== 4'd1) $display("FAIL sel_wrap: got sel=%0d load=%0d want 3/1", sel, load); else n_pass++;
      press(1'b0, 1'b1, 1'b0);
      n_checks++; if (sel !== 2'd2 || load !== 4'd4) $display("FAIL h_lo_unchanged: got sel=%0d load=%0d want 2/4", sel, load); else n_pass++;
   endtask

   task automatic test_one_action();
      do_reset();
      cur_bcd = 16'h1234;
      press(1'b1, 1'b0, 1'b0);
      key_inc = 1'b1;
      repeat (30) @(negedge clk);
      key_inc = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++; if (load !== 4'd2) $display("FAIL held_key_once: got %0d want 2", load); else n_pass++;
`ifdef CLOCK_SET_DEBOUNCE_EN
      key_inc = 1'b1;
      repeat (2) @(negedge clk);
      key_inc = 1'b0;
      repeat (12) @(negedge clk);
      n_checks++; if (load !== 4'd2) $display("FAIL glitch_ignored: got %0d want 2", load); else n_pass++;
`endif
   endtask

   task automatic test_simultaneous();
      logic found;
      logic [3:0] got;
      do_reset();
      cur_bcd = 16'h1234;
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b1);
      n_checks++; if (sel !== 2'd2 || load !== 4'd2) $display("FAIL inc_next_sel: got sel=%0d load=%0d want 2/2", sel, load); else n_pass++;
      repeat (3) press(1'b0, 1'b1, 1'b0);
      n_checks++; if (sel !== 2'd3 || load !== 4'd2) $display("FAIL inc_old_sel: got sel=%0d load=%0d want 3/2", sel, load); else n_pass++;
      key_mode = 1'b1; key_inc = 1'b1;
      found = 1'b0; got = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 10) begin key_mode = 1'b0; key_inc = 1'b0; end
         if (!found && pause === 1'b1 && sel === 2'd3 && blink_mask === 4'b0000 && c > 2) begin
            found = 1'b1; got = load;
         end
      end
      n_checks++; if (!found || got !== 4'd2) $display("FAIL mode_wins: found=%0b load=%0d want 1/2", found, got); else n_pass++;
   endtask

   task automatic test_commit();
      int lat;
      logic [3:0] exp_ld [4];
      exp_ld = '{4'd4, 4'd3, 4'd2, 4'd1};
      do_reset();
      cur_bcd = 16'h1234;
      press(1'b1, 1'b0, 1'b0);
      key_mode = 1'b1;
      lat = 0;
      for (int c = 1; c <= int'(LAT) + 4 && lat == 0; c++) begin
         @(negedge clk);
         if (sel === 2'd0) lat = c;
      end
      n_checks++; if (lat == 0) $display("FAIL commit_start: got no commit within %0d cycles want start", LAT + 4); else n_pass++;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) key_mode = 1'b0;
         if (k == 2) begin key_inc = 1'b1; key_next = 1'b1; end
         if (k == 9) begin key_inc = 1'b0; key_next = 1'b0; end
         n_checks++;
         if (sel !== 2'(k / 4) || load !== exp_ld[k / 4] || pause !== 1'b1 || blink_mask !== 4'b0000)
            $display("FAIL commit_seq[%0d]: got sel=%0d load=%0d pause=%0b blink=%b want %0d/%0d/1/0000",
                     k, sel, load, pause, blink_mask, k / 4, exp_ld[k / 4]);
         else n_pass++;
         n_checks++;
         if (commit_done !== (k == 15)) $display("FAIL commit_done[%0d]: got %0b want %0b", k, commit_done, k == 15);
         else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (pause !== 1'b0 || commit_done !== 1'b0 || sel !== 2'd0 || load !== 4'd0)
         $display("FAIL commit_exit: got pause=%0b done=%0b sel=%0d load=%0d want 0/0/0/0", pause, commit_done, sel, load);
      else n_pass++;
   endtask

   task automatic test_abort();
      int lat;
      logic done_seen;
      logic pause_seen;
      do_reset();
      cur_bcd = 16'h1234;
      press(1'b1, 1'b0, 1'b0);
      key_mode = 1'b1;
      lat = 0;
      for (int c = 1; c <= int'(LAT) + 4 && lat == 0; c++) begin
         @(negedge clk);
         if (sel === 2'd0) lat = c;
      end
      repeat (2) @(negedge clk);
      #2;
      clrn = 1'b0; key_mode = 1'b0;
      #1;
      n_checks++;
      if (pause !== 1'b0 || sel !== 2'd0 || load !== 4'd0 || blink_mask !== 4'b0000)
         $display("FAIL abort_async: got pause=%0b sel=%0d load=%0d blink=%b want 0/0/0/0000", pause, sel, load, blink_mask);
      else n_pass++;
      @(negedge clk);
      clrn = 1'b1;
      done_seen = 1'b0; pause_seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (commit_done !== 1'b0) done_seen = 1'b1;
         if (pause !== 1'b0) pause_seen = 1'b1;
      end
      n_checks++; if (done_seen !== 1'b0) $display("FAIL abort_no_commit: got done_seen=%0b want 0", done_seen); else n_pass++;
      n_checks++; if (pause_seen !== 1'b0) $display("FAIL abort_stays_run: got pause_seen=%0b want 0", pause_seen); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_entry();
      test_clamp();
      test_snapshot_clamp();
      test_wrap();
      test_one_action();
      test_simultaneous();
      test_commit();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
